// File: rtl/dma_fifo_sequencer_if.sv
// Shared bus handshake between the DMA sequencer (master) and the memory fabric (slave).
interface dma_fifo_sequencer_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic              err;

    modport master (
        output req,
        output we,
        output addr,
        input  ack,
        input  err
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        output ack,
        output err
    );
endinterface

// File: rtl/dma_fifo_sequencer.sv
// DMA transfer sequencer: fills an external FIFO from the source in bursts, then drains it
// word by word to the destination, with bounded per-access retry on bus errors.
module dma_fifo_sequencer #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned LEN_W          = 8,
    parameter int unsigned FIFO_ADDR_SIZE = 4,
    parameter int unsigned BURST          = 16,
    parameter int unsigned MAX_RETRY      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    src_addr_i,
    input  logic [ADDR_W-1:0]    dst_addr_i,
    input  logic [LEN_W-1:0]     length_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    dma_fifo_sequencer_if.master bus_if,
    input  logic                 fifo_full_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_enable_o,
    output logic                 fifo_wr_rd_o,
    output logic                 fifo_old_add_flag_o
);
    localparam int unsigned FW = FIFO_ADDR_SIZE + 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [FW-1:0] BurstCnt = FW'(BURST);
    localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRY);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFill  = 3'd1;
    localparam logic [2:0] StPop   = 3'd2;
    localparam logic [2:0] StWr    = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;
    localparam logic [2:0] StAbort = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  rd_left_q, rd_left_d;
    logic [LEN_W-1:0]  wr_left_q, wr_left_d;
    logic [FW-1:0]     fill_cnt_q, fill_cnt_d;
    logic [RW-1:0]     retry_cnt_q, retry_cnt_d;

    logic in_fill, in_wr, fill_req, fill_ack;

    assign in_fill  = (state_q == StFill);
    assign in_wr    = (state_q == StWr);
    // A full FIFO withdraws the read request so an ack can never write into it.
    assign fill_req = in_fill && !fifo_full_i;
    assign fill_ack = fill_req && bus_if.ack;

    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        rd_left_d   = rd_left_q;
        wr_left_d   = wr_left_q;
        fill_cnt_d  = fill_cnt_q;
        retry_cnt_d = retry_cnt_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (length_i != '0) begin
                        src_ptr_d   = src_addr_i;
                        dst_ptr_d   = dst_addr_i;
                        rd_left_d   = length_i;
                        wr_left_d   = length_i;
                        fill_cnt_d  = '0;
                        retry_cnt_d = '0;
                        state_d     = StFill;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StFill: begin
                if (fifo_full_i) begin
                    fill_cnt_d = '0;
                    state_d    = StPop;
                end else if (bus_if.ack) begin
                    src_ptr_d   = src_ptr_q + ADDR_W'(1);
                    rd_left_d   = rd_left_q - LEN_W'(1);
                    fill_cnt_d  = fill_cnt_q + FW'(1);
                    retry_cnt_d = '0;
                    if ((fill_cnt_q + FW'(1)) == BurstCnt || rd_left_q == LEN_W'(1)) begin
                        fill_cnt_d = '0;
                        state_d    = StPop;
                    end
                end else if (bus_if.err) begin
                    if (retry_cnt_q == RetryMax) state_d = StAbort;
                    else retry_cnt_d = retry_cnt_q + RW'(1);
                end
            end
            StPop: state_d = StWr;
            StWr: begin
                if (bus_if.ack) begin
                    dst_ptr_d   = dst_ptr_q + ADDR_W'(1);
                    wr_left_d   = wr_left_q - LEN_W'(1);
                    retry_cnt_d = '0;
                    if (wr_left_q == LEN_W'(1)) state_d = StDone;
                    else if (fifo_empty_i)       state_d = StFill;
                    else                         state_d = StPop;
                end else if (bus_if.err) begin
                    if (retry_cnt_q == RetryMax) state_d = StAbort;
                    else retry_cnt_d = retry_cnt_q + RW'(1);
                end
            end
            StDone:  state_d = StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            rd_left_q   <= '0;
            wr_left_q   <= '0;
            fill_cnt_q  <= '0;
            retry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            rd_left_q   <= rd_left_d;
            wr_left_q   <= wr_left_d;
            fill_cnt_q  <= fill_cnt_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    always_comb begin
        busy_o              = (state_q != StIdle);
        done_o              = (state_q == StDone) || (state_q == StAbort);
        err_o               = (state_q == StAbort);
        bus_if.req          = fill_req || in_wr;
        bus_if.we           = in_wr;
        bus_if.addr         = in_fill ? src_ptr_q : (in_wr ? dst_ptr_q : '0);
        // WR keeps the FIFO enabled with old_add_flag set so the popped word stays put.
        fifo_enable_o       = fill_ack || (state_q == StPop) || in_wr;
        fifo_wr_rd_o        = fill_ack;
        fifo_old_add_flag_o = in_wr;
    end
endmodule

// File: tb/tb_dma_fifo_sequencer.sv
// Scoreboard bench for dma_fifo_sequencer with a behavioural FIFO and a scripted bus slave.
module tb_dma_fifo_sequencer;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned FAS    = 4;
    localparam int          DEPTH  = 16;
    localparam logic [FAS-1:0] One = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic [ADDR_W-1:0] src_addr_i = '0;
    logic [ADDR_W-1:0] dst_addr_i = '0;
    logic [LEN_W-1:0]  length_i = '0;
    logic busy_o, done_o, err_o;
    logic fifo_full, fifo_empty, fifo_enable, fifo_wr_rd, fifo_old;

    dma_fifo_sequencer_if #(.ADDR_W(ADDR_W)) bus_if ();

    dma_fifo_sequencer #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_ADDR_SIZE(FAS), .BURST(16), .MAX_RETRY(4)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .src_addr_i(src_addr_i),
        .dst_addr_i(dst_addr_i), .length_i(length_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .bus_if(bus_if), .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty),
        .fifo_enable_o(fifo_enable), .fifo_wr_rd_o(fifo_wr_rd), .fifo_old_add_flag_o(fifo_old)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic logic [15:0] src_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    // Scoreboard and bus-slave script
    logic [15:0] exp_rd_q[$];
    logic [31:0] exp_wr_q[$];
    int burst_log[$];
    int cur_burst = 0;
    int rd_errs = 0, wr_errs = 0, ack_err_cnt = 0;
    int req_cycles = 0, err_cycles = 0;

    // Behavioural FIFO: write on enable&wr_rd, pop on enable&!wr_rd&!old_flag, hold otherwise
    logic [15:0] fmem[DEPTH];
    logic [FAS-1:0] wp, rp, old;
    int fcount;
    logic do_wr = 1'b0, do_pop = 1'b0;
    logic [15:0] wr_data = '0;
    logic [15:0] fifo_out;

    assign fifo_full  = (fcount == DEPTH);
    assign fifo_empty = (fcount == 0);
    assign fifo_out   = fmem[old];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            old <= '0;
            fcount <= 0;
        end else begin
            if (do_wr) begin
                fmem[wp] <= wr_data;
                wp <= wp + One;
                fcount <= fcount + 1;
            end else if (do_pop) begin
                old <= rp;
                rp <= rp + One;
                fcount <= fcount - 1;
            end
        end
    end

    logic prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [15:0] prev_addr = '0, prev_fout = '0, mon_ra;
    logic [31:0] mon_e;

    // Bus slave drives its response at the falling edge, monitor samples 1 unit later
    always @(negedge clk) begin
        bus_if.ack = 1'b0;
        bus_if.err = 1'b0;
        if (!rst && bus_if.req) begin
            if (bus_if.we && wr_errs > 0) begin
                bus_if.err = 1'b1; wr_errs--;
            end else if (!bus_if.we && rd_errs > 0) begin
                bus_if.err = 1'b1; rd_errs--;
            end else begin
                bus_if.ack = 1'b1;
                if (ack_err_cnt > 0) begin bus_if.err = 1'b1; ack_err_cnt--; end
            end
        end
        #1;
        do_wr = 1'b0;
        do_pop = 1'b0;
        if (rst) begin
            prev_req = 1'b0; prev_ack = 1'b0; cur_burst = 0;
        end else begin
            if (bus_if.req) req_cycles++;
            if (bus_if.err && !bus_if.ack) err_cycles++;
            do_wr  = fifo_enable && fifo_wr_rd;
            do_pop = fifo_enable && !fifo_wr_rd && !fifo_old;
            wr_data = src_word(bus_if.addr);
            if (do_wr) begin
                checks++;
                if (fcount == DEPTH) begin
                    errors++; $display("FAIL fifo_overflow: write with count=%0d", fcount);
                end
            end
            if (do_pop) begin
                checks++;
                if (fcount == 0) begin
                    errors++; $display("FAIL fifo_underflow: pop with count=0");
                end
            end
            if (bus_if.req && prev_req && !prev_ack) begin
                checks++;
                if (bus_if.addr !== prev_addr || bus_if.we !== prev_we ||
                    (bus_if.we && fifo_out !== prev_fout)) begin
                    errors++;
                    $display("FAIL retry_hold: addr=%h we=%b data=%h, required %h %b %h",
                             bus_if.addr, bus_if.we, fifo_out, prev_addr, prev_we, prev_fout);
                end
            end
            if (bus_if.req && bus_if.we) begin
                checks++;
                if (fifo_enable !== 1'b1 || fifo_wr_rd !== 1'b0 || fifo_old !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_fifo_ctrl: en/wr_rd/old=%b%b%b, required 101",
                             fifo_enable, fifo_wr_rd, fifo_old);
                end
            end
            if (bus_if.ack && !bus_if.we) begin
                cur_burst++;
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++; $display("FAIL rd_unexpected: read at %h, none required", bus_if.addr);
                end else begin
                    mon_ra = exp_rd_q.pop_front();
                    if (bus_if.addr !== mon_ra) begin
                        errors++; $display("FAIL rd_addr: got %h, required %h", bus_if.addr, mon_ra);
                    end
                end
                checks++;
                if (do_wr !== 1'b1) begin
                    errors++; $display("FAIL fill_write: fifo write=%b on read ack, required 1", do_wr);
                end
            end
            if (bus_if.ack && bus_if.we) begin
                if (cur_burst != 0) begin burst_log.push_back(cur_burst); cur_burst = 0; end
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++; $display("FAIL wr_unexpected: write at %h, none required", bus_if.addr);
                end else begin
                    mon_e = exp_wr_q.pop_front();
                    if ({bus_if.addr, fifo_out} !== mon_e) begin
                        errors++;
                        $display("FAIL wr_addr_data: got %h/%h, required %h/%h",
                                 bus_if.addr, fifo_out, mon_e[31:16], mon_e[15:0]);
                    end
                end
            end
            prev_req  = bus_if.req;
            prev_ack  = bus_if.ack;
            prev_we   = bus_if.we;
            prev_addr = bus_if.addr;
            prev_fout = fifo_out;
        end
    end

    task automatic run_xfer(input logic [15:0] src, input logic [15:0] dst, input int len,
                            input int budget, output int ncyc, output logic got_done,
                            output logic got_err, output logic first_req);
        for (int i = 0; i < len; i++) begin
            logic [15:0] sa, da;
            sa = src + 16'(i);
            da = dst + 16'(i);
            exp_rd_q.push_back(sa);
            exp_wr_q.push_back({da, src_word(sa)});
        end
        @(negedge clk);
        src_addr_i = src;
        dst_addr_i = dst;
        length_i = LEN_W'(len);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        ncyc = -1;
        got_done = 1'b0;
        got_err = 1'b0;
        first_req = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            #2;
            if (n == 0) first_req = bus_if.req;
            if (done_o) begin
                ncyc = n + 1; got_done = 1'b1; got_err = err_o;
                break;
            end
        end
        if (!got_done) begin
            errors++; $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy_o, done_o, err_o, bus_if.req, bus_if.we, bus_if.addr, fifo_enable,
             fifo_wr_rd, fifo_old} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy/done/err/req/we=%b%b%b%b%b addr=%h fifo=%b%b%b",
                     busy_o, done_o, err_o, bus_if.req, bus_if.we, bus_if.addr,
                     fifo_enable, fifo_wr_rd, fifo_old);
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #2;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b, required 0", busy_o);
        end
    endtask

    task automatic test_basic();
        int n; logic d, e, fr; int r0;
        r0 = req_cycles;
        run_xfer(16'h0100, 16'h0200, 3, 50, n, d, e, fr);
        checks++;
        if (n !== 10 || e !== 1'b0 || fr !== 1'b1) begin
            errors++;
            $display("FAIL basic_timing: cycles=%0d err=%b first_req=%b, required 10 0 1", n, e, fr);
        end
        checks++;
        if (req_cycles - r0 !== 6 || exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL basic_traffic: req_cycles=%0d left rd=%0d wr=%0d, required 6 0 0",
                     req_cycles - r0, exp_rd_q.size(), exp_wr_q.size());
        end
        @(negedge clk);
        #2;
        checks++;
        if ({busy_o, done_o, err_o} !== 3'b000) begin
            errors++; $display("FAIL basic_idle: busy/done/err=%b%b%b, required 000", busy_o, done_o, err_o);
        end
    endtask

    task automatic test_bursts();
        int n; logic d, e, fr;
        burst_log.delete();
        run_xfer(16'h1000, 16'h3000, 40, 400, n, d, e, fr);
        checks++;
        if (n !== 121 || e !== 1'b0) begin
            errors++; $display("FAIL burst_timing: cycles=%0d err=%b, required 121 0", n, e);
        end
        checks++;
        if (burst_log.size() != 3 || burst_log[0] != 16 || burst_log[1] != 16 || burst_log[2] != 8) begin
            errors++;
            $display("FAIL burst_sizes: count=%0d first=%0d, required 16,16,8",
                     burst_log.size(), (burst_log.size() > 0) ? burst_log[0] : -1);
        end
        checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++; $display("FAIL burst_drain: left wr=%0d rd=%0d, required 0 0",
                               exp_wr_q.size(), exp_rd_q.size());
        end
    endtask

    task automatic test_wr_retry();
        int n; logic d, e, fr; int e0;
        e0 = err_cycles;
        wr_errs = 2;
        run_xfer(16'h0400, 16'h0500, 2, 50, n, d, e, fr);
        checks++;
        if (n !== 9 || e !== 1'b0 || err_cycles - e0 !== 2) begin
            errors++;
            $display("FAIL wr_retry: cycles=%0d err=%b bus_errs=%0d, required 9 0 2",
                     n, e, err_cycles - e0);
        end
        checks++;
        if (exp_wr_q.size() != 0) begin
            errors++; $display("FAIL wr_retry_drain: left wr=%0d, required 0", exp_wr_q.size());
        end
    endtask

    task automatic test_abort();
        int n; logic d, e, fr;
        rd_errs = 5;
        run_xfer(16'h0600, 16'h0700, 4, 50, n, d, e, fr);
        checks++;
        if (n !== 6 || e !== 1'b1 || d !== 1'b1) begin
            errors++; $display("FAIL abort: cycles=%0d done=%b err=%b, required 6 1 1", n, d, e);
        end
        @(negedge clk);
        #2;
        checks++;
        if ({busy_o, done_o, err_o} !== 3'b000) begin
            errors++; $display("FAIL abort_idle: busy/done/err=%b%b%b, required 000", busy_o, done_o, err_o);
        end
        exp_rd_q.delete();
        exp_wr_q.delete();
        // Exactly MAX_RETRY errors on one access is still tolerated
        rd_errs = 4;
        run_xfer(16'h0800, 16'h0900, 2, 50, n, d, e, fr);
        checks++;
        if (n !== 11 || e !== 1'b0 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL retry_limit: cycles=%0d err=%b left=%0d, required 11 0 0",
                     n, e, exp_wr_q.size());
        end
    endtask

    task automatic test_wrap();
        int n; logic d, e, fr;
        ack_err_cnt = 2;
        run_xfer(16'hFFFD, 16'hFFFE, 4, 60, n, d, e, fr);
        checks++;
        if (n !== 13 || e !== 1'b0 || exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL wrap: cycles=%0d err=%b left wr=%0d rd=%0d, required 13 0 0 0",
                     n, e, exp_wr_q.size(), exp_rd_q.size());
        end
    endtask

    task automatic test_zero_len();
        int n; logic d, e, fr; int r0;
        r0 = req_cycles;
        run_xfer(16'h1234, 16'h5678, 0, 10, n, d, e, fr);
        checks++;
        if (n !== 1 || e !== 1'b0 || req_cycles - r0 !== 0) begin
            errors++;
            $display("FAIL zero_len: cycles=%0d err=%b req_cycles=%0d, required 1 0 0",
                     n, e, req_cycles - r0);
        end
    endtask

    task automatic test_reset_mid();
        int n; logic d, e, fr; logic seen;
        for (int i = 0; i < 8; i++) begin
            exp_rd_q.push_back(16'h2000 + 16'(i));
            exp_wr_q.push_back({16'h2100 + 16'(i), src_word(16'h2000 + 16'(i))});
        end
        @(negedge clk);
        src_addr_i = 16'h2000; dst_addr_i = 16'h2100; length_i = 8'd8; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #2;
            if (bus_if.req && bus_if.we) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL reset_mid_wait: WR not reached, required within 100 cycles");
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_o, done_o, err_o, bus_if.req, bus_if.we, bus_if.addr, fifo_enable,
             fifo_wr_rd, fifo_old} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy/done/err/req/we=%b%b%b%b%b addr=%h, required 0",
                     busy_o, done_o, err_o, bus_if.req, bus_if.we, bus_if.addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2;
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++; $display("FAIL reset_mid_hold: done=%b busy=%b, required 0 0", done_o, busy_o);
            end
        end
        exp_rd_q.delete();
        exp_wr_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        run_xfer(16'h2200, 16'h2300, 5, 60, n, d, e, fr);
        checks++;
        if (n !== 16 || e !== 1'b0 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_rerun: cycles=%0d err=%b left=%0d, required 16 0 0",
                     n, e, exp_wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bursts();
        test_wr_retry();
        test_abort();
        test_wrap();
        test_zero_len();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
